forward_bypass_net: RTL and testbench

- Parametrised operand-forwarding network for the RISC-V pipeline; the generalised successor of the single MEM/WB forward path.
- Resolves NUM_SRC source operands against the EX/MEM result, the MEM/WB result, and a DEPTH-entry history of retired writebacks.
- The history covers the write-to-read latency of the FPGA block-RAM register file.
- Sits beside the ID/EX stage and drives the forwarded operand values into the ALU input muxes.

---
 rtl/forward_bypass_net_pkg.sv | 22 ++
 rtl/forward_bypass_net_select.sv | 49 ++++
 rtl/forward_bypass_net.sv | 110 +++++++++++
 tb/tb_forward_bypass_net.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/forward_bypass_net_pkg.sv
// Shared select encoding, writeback history entry type and select-width helper
// for the operand forwarding network.
package forward_pkg;

    localparam int XLEN = 32;

    localparam int SEL_RF    = 0;
    localparam int SEL_EXMEM = 1;
    localparam int SEL_MEMWB = 2;
    localparam int SEL_HIST0 = 3;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/forward_bypass_net_select.sv
// Single-port priority resolver: EX/MEM > MEM/WB > youngest history > register file.
// Purely combinational; x0 always resolves to zero from the register file.
module forward_select
    import forward_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int SEL_W = 3
) (
    input  logic [4:0]                 rs_addr,
    input  logic                       exmem_vld,
    input  logic [4:0]                 exmem_rd,
    input  logic [XLEN-1:0]            exmem_data,
    input  logic                       memwb_vld,
    input  logic [4:0]                 memwb_rd,
    input  logic [XLEN-1:0]            memwb_data,
    input  logic [DEPTH-1:0]           hist_vld,
    input  logic [DEPTH-1:0][4:0]      hist_rd,
    input  logic [DEPTH-1:0][XLEN-1:0] hist_data,
    input  logic [XLEN-1:0]            rf_data,
    output logic [XLEN-1:0]            data,
    output logic [SEL_W-1:0]           sel
);

    // Walk from lowest to highest priority so the youngest match overrides.
    always_comb begin
        data = rf_data;
        sel  = SEL_W'(SEL_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_vld[i] && (hist_rd[i] == rs_addr)) begin
                data = hist_data[i];
                sel  = SEL_W'(SEL_HIST0 + i);
            end
        end
        if (memwb_vld && (memwb_rd == rs_addr)) begin
            data = memwb_data;
            sel  = SEL_W'(SEL_MEMWB);
        end
        if (exmem_vld && (exmem_rd == rs_addr)) begin
            data = exmem_data;
            sel  = SEL_W'(SEL_EXMEM);
        end
        if (rs_addr == 5'd0) begin
            data = '0;
            sel  = SEL_W'(SEL_RF);
        end
    end

endmodule

// File: rtl/forward_bypass_net.sv
// Operand forwarding network: resolves NUM_SRC operands against EX/MEM, MEM/WB and a
// DEPTH-deep retired-writeback history covering block-RAM register file write latency.
module forward_bypass_net
    import forward_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32,
    localparam int SEL_W  = sel_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         exmem_we,
    input  logic [4:0]                   exmem_rd,
    input  logic [XLEN-1:0]              exmem_data,
    input  logic                         memwb_we,
    input  logic [4:0]                   memwb_rd,
    input  logic [XLEN-1:0]              memwb_data,
    input  logic [NUM_SRC-1:0][4:0]      rs_addr,
    input  logic [NUM_SRC-1:0][XLEN-1:0] rf_data,
    output logic [NUM_SRC-1:0][XLEN-1:0] fwd_data,
    output logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel,
    output logic [CNT_W-1:0]             hit_count
);

    localparam int ADD_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = CNT_W + ADD_W;

    logic [DEPTH-1:0]           hist_vld;
    logic [DEPTH-1:0][4:0]      hist_rd;
    logic [DEPTH-1:0][XLEN-1:0] hist_data;

    logic exmem_vld;
    logic memwb_vld;

    assign exmem_vld = exmem_we && !flush && (exmem_rd != 5'd0);
    assign memwb_vld = memwb_we && (memwb_rd != 5'd0);

    // flush deliberately ignored here: retired writes are architectural.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_vld <= '0;
            hist_rd  <= '0;
        end else if (!stall) begin
            hist_vld[0] <= memwb_vld;
            hist_rd[0]  <= memwb_rd;
            for (int i = 1; i < DEPTH; i++) begin
                hist_vld[i] <= hist_vld[i-1];
                hist_rd[i]  <= hist_rd[i-1];
            end
        end
    end

    // Data is never observed unless the matching valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            hist_data[0] <= memwb_data;
            for (int i = 1; i < DEPTH; i++) begin
                hist_data[i] <= hist_data[i-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
        forward_select #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_select (
            .rs_addr    (rs_addr[p]),
            .exmem_vld  (exmem_vld),
            .exmem_rd   (exmem_rd),
            .exmem_data (exmem_data),
            .memwb_vld  (memwb_vld),
            .memwb_rd   (memwb_rd),
            .memwb_data (memwb_data),
            .hist_vld   (hist_vld),
            .hist_rd    (hist_rd),
            .hist_data  (hist_data),
            .rf_data    (rf_data[p]),
            .data       (fwd_data[p]),
            .sel        (fwd_sel[p])
        );
    end

    logic [ADD_W-1:0] hits;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        hits = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            if (fwd_sel[p] != SEL_W'(SEL_RF)) begin
                hits = hits + ADD_W'(1);
            end
        end
        cnt_sum = SUM_W'(hit_count) + SUM_W'(hits);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (!stall) begin
            hit_count <= (cnt_sum[SUM_W-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_forward_bypass_net.sv
// Directed bench for forward_bypass_net: queue-based reference model checked every cycle
// plus literal expectations; a second instance with a 3-bit counter exercises saturation.
module tb_forward_bypass_net;
    import forward_pkg::*;

    localparam int NS = 2;
    localparam int DP = 2;
    localparam int SW = sel_width(DP);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                stall, flush;
    logic                exmem_we, memwb_we;
    logic [4:0]          exmem_rd, memwb_rd;
    logic [31:0]         exmem_data, memwb_data;
    logic [NS-1:0][4:0]  rs_addr;
    logic [NS-1:0][31:0] rf_data;
    logic [NS-1:0][31:0] fwd_data, sat_data;
    logic [NS-1:0][SW-1:0] fwd_sel, sat_sel;
    logic [31:0]         hit_count;
    logic [2:0]          sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_entry_t m_hist[$];
    longint    m_cnt = 0;

    always #5 clk = ~clk;

    forward_bypass_net #(.XLEN(32), .NUM_SRC(NS), .DEPTH(DP), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .hit_count(hit_count)
    );

    forward_bypass_net #(.XLEN(32), .NUM_SRC(NS), .DEPTH(DP), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_data(sat_data), .fwd_sel(sat_sel), .hit_count(sat_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest matching producer wins; x0 is hardwired zero.
    function automatic void model_lookup(input int p, output logic [31:0] d, output int s);
        d = rf_data[p];
        s = 0;
        if (rs_addr[p] == 5'd0) begin
            d = '0;
            return;
        end
        if (exmem_we && !flush && exmem_rd != 5'd0 && exmem_rd == rs_addr[p]) begin
            d = exmem_data; s = 1; return;
        end
        if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs_addr[p]) begin
            d = memwb_data; s = 2; return;
        end
        foreach (m_hist[i]) begin
            if (m_hist[i].valid && m_hist[i].rd == rs_addr[p]) begin
                d = m_hist[i].data; s = 3 + i; return;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        int          h;
        logic [31:0] d;
        int          s;
        wb_entry_t   e;
        if (rst) begin
            m_hist.delete();
            m_cnt = 0;
        end else if (!stall) begin
            h = 0;
            for (int p = 0; p < NS; p++) begin
                model_lookup(p, d, s);
                if (s != 0) h++;
            end
            m_cnt += h;
            e.valid = memwb_we && (memwb_rd != 5'd0);
            e.rd    = memwb_rd;
            e.data  = memwb_data;
            m_hist.push_front(e);
            if (m_hist.size() > DP) void'(m_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        logic [31:0] d;
        int          s;
        for (int p = 0; p < NS; p++) begin
            model_lookup(p, d, s);
            chk($sformatf("model fwd_data[%0d]", p), fwd_data[p], d);
            chk($sformatf("model fwd_sel[%0d]", p), fwd_sel[p], s);
            chk($sformatf("model sat fwd_sel[%0d]", p), sat_sel[p], s);
        end
        chk("model hit_count", hit_count, (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt);
        chk("model sat hit_count", sat_count, (m_cnt > 7) ? 7 : m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 0; flush = 0;
        exmem_we = 0; exmem_rd = 0; exmem_data = 0;
        memwb_we = 0; memwb_rd = 0; memwb_data = 0;
        rs_addr[0] = 5'd1; rs_addr[1] = 5'd2;
        rf_data[0] = 32'h11; rf_data[1] = 32'h22;

        repeat (2) @(posedge clk);
        #1;
        chk("reset fwd_data0", fwd_data[0], 32'h11);
        chk("reset fwd_data1", fwd_data[1], 32'h22);
        chk("reset fwd_sel0", fwd_sel[0], 0);
        chk("reset fwd_sel1", fwd_sel[1], 0);
        chk("reset hit_count", hit_count, 0);
        rst = 0;
        tick();

        exmem_we = 1; exmem_rd = 5'd5; exmem_data = 32'hAAAA0001;
        memwb_we = 1; memwb_rd = 5'd5; memwb_data = 32'hBBBB0002;
        rs_addr[0] = 5'd5;
        #1;
        chk("exmem wins data", fwd_data[0], 32'hAAAA0001);
        chk("exmem wins sel", fwd_sel[0], 1);
        flush = 1;
        #1;
        chk("flush memwb data", fwd_data[0], 32'hBBBB0002);
        chk("flush memwb sel", fwd_sel[0], 2);
        tick();
        exmem_we = 0; flush = 0; memwb_we = 0;
        #1;
        chk("flush keeps hist data", fwd_data[0], 32'hBBBB0002);
        chk("flush keeps hist sel", fwd_sel[0], 3);
        rs_addr[0] = 5'd0;

        tick();
        rs_addr[1] = 5'd7; rf_data[1] = 32'hDEAD;
        memwb_we = 1; memwb_rd = 5'd7; memwb_data = 32'hCAFE;
        tick();
        memwb_we = 0;
        #1;
        chk("walk hist0 sel", fwd_sel[1], 3);
        chk("walk hist0 data", fwd_data[1], 32'hCAFE);
        tick();
        chk("walk hist1 sel", fwd_sel[1], 4);
        chk("walk hist1 data", fwd_data[1], 32'hCAFE);
        tick();
        chk("walk expired sel", fwd_sel[1], 0);
        chk("walk expired data", fwd_data[1], 32'hDEAD);

        rs_addr[1] = 5'd0;
        memwb_we = 1; memwb_rd = 5'd9; memwb_data = 32'h9999;
        tick();
        memwb_we = 0; stall = 1; rs_addr[0] = 5'd9;
        repeat (3) tick();
        chk("stall hold sel", fwd_sel[0], 3);
        chk("stall hold data", fwd_data[0], 32'h9999);
        stall = 0;

        rst = 1;
        #1;
        rst = 0;
        chk("reset clears count", hit_count, 0);
        memwb_we = 1; memwb_rd = 5'd0; memwb_data = 32'hFFFF;
        rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
        #1;
        chk("x0 data0", fwd_data[0], 0);
        chk("x0 data1", fwd_data[1], 0);
        chk("x0 sel0", fwd_sel[0], 0);
        chk("x0 sel1", fwd_sel[1], 0);
        tick();
        chk("x0 no count", hit_count, 0);
        memwb_rd = 5'd12; memwb_data = 32'h1234;
        rs_addr[0] = 5'd12; rs_addr[1] = 5'd12;
        repeat (4) tick();
        chk("count both ports", hit_count, 8);
        chk("count saturates", sat_count, 7);

        memwb_rd = 5'd3; memwb_data = 32'h3333;
        rs_addr[0] = 5'd3; rs_addr[1] = 5'd0;
        tick();
        memwb_we = 0;
        #1;
        chk("pre-reset hist sel", fwd_sel[0], 3);
        #1;
        rst = 1;
        #1;
        chk("async reset sel", fwd_sel[0], 0);
        chk("async reset data", fwd_data[0], 32'h11);
        chk("async reset count", hit_count, 0);
        #1;
        rst = 0;

        tick();
        memwb_we = 1; memwb_rd = 5'd4; memwb_data = 32'hA;
        tick();
        memwb_data = 32'hB;
        tick();
        memwb_we = 0;
        rs_addr[0] = 5'd4; rs_addr[1] = 5'd4;
        #1;
        chk("youngest hist data0", fwd_data[0], 32'hB);
        chk("youngest hist data1", fwd_data[1], 32'hB);
        chk("youngest hist sel1", fwd_sel[1], 3);
        exmem_we = 1; exmem_rd = 5'd4; exmem_data = 32'hE4;
        #1;
        chk("exmem over hist sel0", fwd_sel[0], 1);
        chk("exmem over hist data1", fwd_data[1], 32'hE4);
        tick();
        exmem_we = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
